// File: rtl/uart_rx_core.sv
// UART receive engine: oversampled start detection, LSB-first data, optional parity, 1/2 stop bits.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote over the last three ticks.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 sreset,
  input  logic                 en,
  input  logic                 tick,
  input  logic                 rx,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_HALF  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_ONE   = SW'(1);
  localparam logic [NW-1:0] N_FINAL = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] N_ONE   = NW'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SW-1:0]          s_q, s_d;
  logic [NW-1:0]          n_q, n_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   last_rx_q, last_rx_d;
  logic                   par_acc_q, par_acc_d;
  logic                   par_flag_q, par_flag_d;
  logic                   frm_flag_q, frm_flag_d;
  logic [1:0]             cfg_par_q, cfg_par_d;
  logic                   cfg_stop2_q, cfg_stop2_d;
  logic                   stop_second_q, stop_second_d;
  logic                   adv;
  logic                   sample;
  logic                   parity_on;

  assign adv       = en && tick;
  assign parity_on = (cfg_par_q == 2'b01) || (cfg_par_q == 2'b10);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // hist_q holds rx from the two previous ticks, so the vote spans decision s-2..s.
  logic [1:0] hist_q, hist_d;
  assign hist_d = adv ? {hist_q[0], rx} : hist_q;
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)   hist_q <= 2'b11;
    else if (sreset) hist_q <= 2'b11;
    else             hist_q <= hist_d;
  end
`else
  assign sample = rx;
`endif

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= ST_IDLE;  s_q <= '0;  n_q <= '0;  shift_q <= '0;  data_q <= '0;
      valid_q <= 1'b0;  perr_q <= 1'b0;  ferr_q <= 1'b0;  last_rx_q <= 1'b1;
      par_acc_q <= 1'b0;  par_flag_q <= 1'b0;  frm_flag_q <= 1'b0;
      cfg_par_q <= 2'b00;  cfg_stop2_q <= 1'b0;  stop_second_q <= 1'b0;
    end else if (sreset) begin
      state_q <= ST_IDLE;  s_q <= '0;  n_q <= '0;  shift_q <= '0;  data_q <= '0;
      valid_q <= 1'b0;  perr_q <= 1'b0;  ferr_q <= 1'b0;  last_rx_q <= 1'b1;
      par_acc_q <= 1'b0;  par_flag_q <= 1'b0;  frm_flag_q <= 1'b0;
      cfg_par_q <= 2'b00;  cfg_stop2_q <= 1'b0;  stop_second_q <= 1'b0;
    end else begin
      state_q <= state_d;  s_q <= s_d;  n_q <= n_d;  shift_q <= shift_d;  data_q <= data_d;
      valid_q <= valid_d;  perr_q <= perr_d;  ferr_q <= ferr_d;  last_rx_q <= last_rx_d;
      par_acc_q <= par_acc_d;  par_flag_q <= par_flag_d;  frm_flag_q <= frm_flag_d;
      cfg_par_q <= cfg_par_d;  cfg_stop2_q <= cfg_stop2_d;  stop_second_q <= stop_second_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    n_d           = n_q;
    shift_d       = shift_q;
    last_rx_d     = adv ? rx : last_rx_q;
    par_acc_d     = par_acc_q;
    par_flag_d    = par_flag_q;
    frm_flag_d    = frm_flag_q;
    cfg_par_d     = cfg_par_q;
    cfg_stop2_d   = cfg_stop2_q;
    stop_second_d = stop_second_q;
    case (state_q)
      ST_IDLE: begin
        if (adv && !rx && last_rx_q) begin
          s_d     = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (adv) begin
          if (s_q != S_HALF) begin
            s_d = s_q + S_ONE;
          end else if (sample) begin
            state_d = ST_IDLE;
          end else begin
            // Frame configuration is frozen here for the rest of the frame.
            s_d           = '0;
            n_d           = '0;
            cfg_par_d     = parity_mode;
            cfg_stop2_d   = stop2;
            par_acc_d     = 1'b0;
            par_flag_d    = 1'b0;
            frm_flag_d    = 1'b0;
            stop_second_d = 1'b0;
            state_d       = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (adv) begin
          if (s_q != S_LAST) begin
            s_d = s_q + S_ONE;
          end else begin
            shift_d   = {sample, shift_q[DATA_BITS-1:1]};
            par_acc_d = par_acc_q ^ sample;
            s_d       = '0;
            n_d       = n_q + N_ONE;
            if (n_q == N_FINAL) state_d = parity_on ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (adv) begin
          if (s_q != S_LAST) begin
            s_d = s_q + S_ONE;
          end else begin
            par_flag_d = (cfg_par_q == 2'b01) ? (par_acc_q ^ sample) : ~(par_acc_q ^ sample);
            s_d        = '0;
            state_d    = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (adv) begin
          if (s_q != S_LAST) begin
            s_d = s_q + S_ONE;
          end else begin
            if (!sample) frm_flag_d = 1'b1;
            s_d = '0;
            if (cfg_stop2_q && !stop_second_q) stop_second_d = 1'b1;
            else                               state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pulses follow the next state directly, so they drop when DONE is left regardless of en.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    valid_d = (state_d == ST_DONE);
    perr_d  = valid_d && par_flag_d;
    ferr_d  = valid_d && frm_flag_d;
    data_d  = valid_d ? shift_d : data_q;
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core (DATA_BITS=8, OVERSAMPLE=16, one tick per clk).
// Expectations for the s=15 glitch frame depend on UART_RX_MAJORITY_VOTE_EN.
module tb_uart_rx_core;
  logic       clk = 1'b0;
  logic       areset_n, sreset, en, tick, rx, stop2;
  logic [1:0] parity_mode;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, busy;

  int n_checks = 0;
  int n_fails  = 0;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .areset_n(areset_n), .sreset(sreset), .en(en), .tick(tick), .rx(rx),
    .parity_mode(parity_mode), .stop2(stop2), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  int         vcount    = 0;
  int         busy_cnt  = 0;
  int         valid_cyc = 0;
  logic [7:0] got_data  = '0;
  logic       got_perr  = 1'b0;
  logic       got_ferr  = 1'b0;
  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (valid) begin
      vcount    <= vcount + 1;
      valid_cyc <= cyc;
      got_data  <= data;
      got_perr  <= parity_err;
      got_ferr  <= frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wire image of one frame: bit 0 is the start bit, unused upper bits idle high.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic has_par,
                                             input logic pbit, input logic sb1, input logic sb2);
    logic [15:0] f;
    int k;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    k = 9;
    if (has_par) begin
      f[k] = pbit;
      k++;
    end
    f[k]   = sb1;
    f[k+1] = sb2;
    return f;
  endfunction

  int start_cyc = 0;

  // Drive nclk clocks of the wire image (16 clocks per bit); optional one-clock glitch
  // and a 3-clock en drop, both given as clock indices within the frame.
  task automatic send_wire(input logic [15:0] bits, input int nclk, input int glitch,
                           input int en_off, input logic final_rx);
    for (int j = 0; j < nclk; j++) begin
      @(negedge clk);
      if (j == 0) start_cyc = cyc;
      rx = bits[j/16] ^ (j == glitch);
      if (j == en_off) en = 1'b0;
      if (en_off >= 0 && j == en_off + 3) en = 1'b1;
    end
    @(negedge clk);
    rx = final_rx;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int vb;
    int bb;
    areset_n = 1'b0; sreset = 1'b0; en = 1'b1; tick = 1'b1; rx = 1'b1;
    parity_mode = 2'b00; stop2 = 1'b0;
    idle(3);
    areset_n = 1'b1;
    idle(1);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_data", data, 0);
    check("reset_perr", parity_err, 0);
    check("reset_ferr", frame_err, 0);

    // Plain 8N1 frame
    vb = vcount;
    send_wire(frame_bits(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1), 160, -1, -1, 1'b1);
    idle(8);
    check("t1_count", vcount - vb, 1);
    check("t1_data", got_data, 8'hA5);
    check("t1_perr", got_perr, 0);
    check("t1_ferr", got_ferr, 0);
    check("t1_latency", valid_cyc - start_cyc, 153);
    check("t1_busy_after", busy, 0);
    check("t1_data_hold", data, 8'hA5);

    // en dropped for 3 clocks while in DONE stretches valid to 4 clocks
    vb = vcount;
    send_wire(frame_bits(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1), 160, -1, 153, 1'b1);
    idle(8);
    check("en_hold_count", vcount - vb, 4);
    check("en_hold_data", got_data, 8'h5A);

    // Even parity: 0x3C has four ones, so parity bit 1 is wrong and 0 is right
    parity_mode = 2'b01;
    vb = vcount;
    send_wire(frame_bits(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1), 176, -1, -1, 1'b1);
    idle(8);
    check("t2_bad_count", vcount - vb, 1);
    check("t2_bad_data", got_data, 8'h3C);
    check("t2_bad_perr", got_perr, 1);
    check("t2_bad_ferr", got_ferr, 0);
    check("t2_latency", valid_cyc - start_cyc, 169);
    vb = vcount;
    send_wire(frame_bits(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1), 176, -1, -1, 1'b1);
    idle(8);
    check("t2_good_count", vcount - vb, 1);
    check("t2_good_perr", got_perr, 0);
    // Odd parity: same byte, parity bit 1 is correct
    parity_mode = 2'b10;
    send_wire(frame_bits(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1), 176, -1, -1, 1'b1);
    idle(8);
    check("t2_odd_perr", got_perr, 0);
    check("t2_odd_data", got_data, 8'h3C);

    // Two stop bits, second one low, line then held low
    parity_mode = 2'b00;
    stop2 = 1'b1;
    vb = vcount;
    send_wire(frame_bits(8'h81, 1'b0, 1'b0, 1'b1, 1'b0), 176, -1, -1, 1'b0);
    idle(4);
    check("t3_count", vcount - vb, 1);
    check("t3_data", got_data, 8'h81);
    check("t3_ferr", got_ferr, 1);
    check("t3_perr", got_perr, 0);
    check("t3_latency", valid_cyc - start_cyc, 169);
    vb = vcount;
    bb = busy_cnt;
    idle(60);
    check("t3_low_busy", busy_cnt - bb, 0);
    check("t3_low_count", vcount - vb, 0);
    rx = 1'b1;
    stop2 = 1'b0;
    idle(20);

    // Short low glitch: false start
    vb = vcount;
    bb = busy_cnt;
    send_wire(16'hFFFE, 4, -1, -1, 1'b1);
    idle(24);
    check("t4_busy_seen", (busy_cnt - bb) > 0, 1);
    check("t4_busy_end", busy, 0);
    check("t4_count", vcount - vb, 0);

    // Async reset in the middle of data bit 4, then a clean frame
    vb = vcount;
    send_wire(frame_bits(8'h55, 1'b0, 1'b0, 1'b1, 1'b1), 88, -1, -1, 1'b1);
    areset_n = 1'b0;
    idle(2);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_data", data, 0);
    areset_n = 1'b1;
    idle(20);
    check("t5_abort_count", vcount - vb, 0);
    send_wire(frame_bits(8'h55, 1'b0, 1'b0, 1'b1, 1'b1), 160, -1, -1, 1'b1);
    idle(8);
    check("t5_count", vcount - vb, 1);
    check("t5_data", got_data, 8'h55);

    // Synchronous clear mid-frame
    vb = vcount;
    send_wire(frame_bits(8'h33, 1'b0, 1'b0, 1'b1, 1'b1), 88, -1, -1, 1'b1);
    sreset = 1'b1;
    idle(1);
    sreset = 1'b0;
    check("sr_busy", busy, 0);
    check("sr_data", data, 0);
    idle(20);
    check("sr_count", vcount - vb, 0);

    // One-clock inversion inside data bit 0 of 0xFF (clock 23 is s=14, clock 24 is s=15)
    vb = vcount;
    send_wire(frame_bits(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1), 160, 23, -1, 1'b1);
    idle(8);
    check("t6_s14_count", vcount - vb, 1);
    check("t6_s14_data", got_data, 8'hFF);
    vb = vcount;
    send_wire(frame_bits(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1), 160, 24, -1, 1'b1);
    idle(8);
    check("t6_s15_count", vcount - vb, 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    check("t6_s15_data", got_data, 8'hFF);
`else
    check("t6_s15_data", got_data, 8'hFE);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Parametrised UART receive engine: oversampled start detection, DATA_BITS LSB-first data, optional even/odd parity, 1 or 2 stop bits, with on-chip shift register and output holding register. It is the next-generation RX controller for the UART datapath. A baud generator supplies `tick` at OVERSAMPLE x baud. The host FIFO or register file consumes `data` on `valid`.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
OVERSAMPLE, 16, ticks per bit; even, >=8.

Ports:
clk  in  1  clock
areset_n  in  1  asynchronous reset, active-low
sreset  in  1  synchronous clear; same effect as areset_n; priority over en
en  in  1  clock enable; when low all state and outputs freeze (except pulses: see Behaviour)
tick  in  1  oversample strobe, 1 clk wide
rx  in  1  serial input, already synchronised to clk
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
stop2  in  1  1 = two stop bits checked
data  out  DATA_BITS  last received word, LSB = first bit on wire
valid  out  1  1-clk pulse: new frame complete
parity_err  out  1  1-clk pulse with valid: parity mismatch
frame_err  out  1  1-clk pulse with valid: any stop bit sampled 0
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (areset_n low or sreset high): state IDLE, s=0, n=0, shift=0, data=0, valid/parity_err/frame_err/busy=0, last_rx=1. The block aborts mid-frame with no pulse.
- Counters: s is $clog2(OVERSAMPLE) bits; n is $clog2(DATA_BITS+1) bits. They advance only on en && tick.
- last_rx updates to rx on every en && tick.
- IDLE: on tick with rx=0 and last_rx=1 (falling edge), set s=0 and go to START. A line held low never restarts.
- START: on tick, s++. At s==OVERSAMPLE/2-1, sample rx (decision point):
  - If 1: false start, return to IDLE. No pulses.
  - If 0: set s=0, n=0, latch parity_mode/stop2 into frame config, go to DATA.
  - Config changes mid-frame are ignored.
- DATA: on tick, s++. At s==OVERSAMPLE-1 (bit centre):
  - Shift the sampled bit into the MSB of the DATA_BITS shift register (right shift), and XOR it into the running parity.
  - Set s=0, n++.
  - When n reaches DATA_BITS, go to PARITY if the latched mode is 01/10, else go to STOP.
- PARITY: sample at s==OVERSAMPLE-1.
  - Even: error if XOR(data, pbit)=1.
  - Odd: error if XOR(data, pbit)=0.
  - Latch the error flag, set s=0, go to STOP.
- STOP: sample at s==OVERSAMPLE-1. A 0 sets the sticky frame flag.
  - If stop2 is latched and this is the first stop bit, set s=0 and remain in STOP for the second bit.
  - Otherwise go to DONE.
- DONE (exactly 1 clk, independent of tick):
  - data <= shift.
  - valid=1; parity_err and frame_err driven from the latched flags.
  - Next state is IDLE.
  - data is updated even on error and holds until the next DONE.
- Latency: valid rises on the clk edge after the tick carrying the final stop-bit decision.
- Pulses are registered outputs. They clear the cycle after DONE even if en drops then. en low while in DONE holds DONE, so valid extends.
- With DATA_BITS<8, data holds only DATA_BITS bits. Data bits are never sampled beyond DATA_BITS.

Optional Feature:
Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: each decision point uses a 2-of-3 majority of rx samples taken at decision s-2, s-1 and s (START at OVERSAMPLE/2-3..OVERSAMPLE/2-1; other states at OVERSAMPLE-3..OVERSAMPLE-1). This adds a 2-bit vote history register.
- Not defined: single sample at the decision tick only.
- Timing is identical in both cases.

Test Plan:
1. OS=16, DB=8, mode 00, stop2=0; send 0xA5 at 1 tick/clk. Required: one valid pulse, data=0xA5, both errs 0, busy low after DONE.
2. Mode 01 (even). Send 0x3C with parity bit 1 (wrong). Required: valid with parity_err=1, data=0x3C. Then send 0x3C with parity 0: parity_err=0.
3. stop2=1, second stop bit driven 0, byte 0x81. Required: frame_err=1 with valid, data=0x81. Hold rx low afterwards: no new start until rx returns high.
4. rx low for 4 ticks, then high (glitch). Required: false start, busy pulses then returns low, no valid.
5. Assert areset_n low at mid DATA bit 4, then send 0x55. Required: only one valid, data=0x55, no pulse for the aborted frame.
6. Single-tick rx inversion at s=14 inside data bit 0 of 0xFF (last clean sample tick removed). Required: with UART_RX_MAJORITY_VOTE_EN defined, data=0xFF. Without it, if the glitch is placed at s=15, data=0xFE.
